// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: buffers bus words and issues one load strobe per frame.
// Define UART_TX_FIFO_OVF_EN to add the sticky OVERFLOW flag and OVF_CLR input.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  input  logic                  TX_BUSY
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                  OVERFLOW,
  input  logic                  OVF_CLR
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L =
    (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic                    wr_acc;
  logic                    issue;

  assign FULL   = (LEVEL == DEPTH_L);
  assign EMPTY  = (LEVEL == '0);
  assign wr_acc = WR_EN && !FULL;

  // Issue FSM: one strobe, then wait for busy to rise and fall.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!EMPTY && !TX_BUSY) begin
          issue   = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (TX_BUSY) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!TX_BUSY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Storage array; contents deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr] <= WR_DATA;
  end

  // Pointers and occupancy counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      LEVEL  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (issue)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      unique case (1'b1)
        (wr_acc && !issue): LEVEL <= LEVEL + (DEPTH_LOG2+1)'(1);
        (!wr_acc && issue): LEVEL <= LEVEL - (DEPTH_LOG2+1)'(1);
        default:            LEVEL <= LEVEL;
      endcase
    end
  end

  // Transmitter load port: data held between issues, strobe one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
    end else begin
      TX_DATA_VALID <= issue;
      if (issue) TX_P_DATA <= mem[rd_ptr];
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Sticky dropped-write flag; a new drop beats a clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                OVERFLOW <= 1'b0;
    else if (WR_EN && FULL)  OVERFLOW <= 1'b1;
    else if (OVF_CLR)        OVERFLOW <= 1'b0;
  end
`endif

endmodule
